// File: rtl/mem_stage_pkg.sv
// Shared CPU parameter header: one-hot instruction indices, sll reset encoding,
// store-data bypass select encodings and the Tuse/Tnew decrement helper.
package mem_stage_pkg;

    localparam int unsigned INSTR_W = 60;

    localparam int unsigned I_SLL  = 0;
    localparam int unsigned I_ADDU = 1;
    localparam int unsigned I_SUBU = 2;
    localparam int unsigned I_ORI  = 3;
    localparam int unsigned I_LUI  = 4;
    localparam int unsigned I_BEQ  = 5;
    localparam int unsigned I_J    = 6;
    localparam int unsigned I_JAL  = 7;
    localparam int unsigned I_JR   = 8;
    localparam int unsigned I_LW   = 20;
    localparam int unsigned I_SW   = 21;
    localparam int unsigned I_LB   = 22;
    localparam int unsigned I_LBU  = 23;
    localparam int unsigned I_LH   = 24;
    localparam int unsigned I_LHU  = 25;
    localparam int unsigned I_SB   = 26;
    localparam int unsigned I_SH   = 27;

    localparam logic [INSTR_W-1:0] INSTR_SLL = {{(INSTR_W-1){1'b0}}, 1'b1} << I_SLL;

    typedef enum logic {
        DMWD_SEL_EXMEM = 1'b0,
        DMWD_SEL_WB    = 1'b1
    } dmwd_sel_e;

    function automatic logic [2:0] sat_dec3(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Data memory: word array with per-byte write enables, combinational read,
// and a synchronous active-low clear that overrides any write in that cycle.
module dm_ram #(
    parameter  int unsigned DM_WORDS = 4096,
    localparam int unsigned AW       = $clog2(DM_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DM_WORDS];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: store-data select, DM access, load extension and Mem/WB registers.
// Optional macro DM_SUBWORD_EN enables sb/sh/lb/lbu/lh/lhu; otherwise only lw/sw.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = 4096,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        PC_EX_to_Mem,
    input  logic [31:0]        ALUOut_EX_to_Mem,
    input  logic [31:0]        DMWriteData_EX_to_Mem,
    input  logic [4:0]         RAddr0_EX_to_Mem,
    input  logic [4:0]         RAddr1_EX_to_Mem,
    input  logic [4:0]         RegWriteAddr_EX_to_Mem,
    input  logic [INSTR_W-1:0] InstrType_EX_to_Mem,
    input  logic [2:0]         Tuse_RAddr0_EX_to_Mem,
    input  logic [2:0]         Tuse_RAddr1_EX_to_Mem,
    input  logic [2:0]         Tnew_WAddr_EX_to_Mem,
    input  logic [31:0]        bypass_WB,
    input  logic               DMWriteDataBypassCtrl_Mem,
    output logic [31:0]        PC_Mem_to_WB,
    output logic [31:0]        ALUOut_Mem_to_WB,
    output logic [31:0]        DMReadData_Mem_to_WB,
    output logic [4:0]         RegWriteAddr_Mem_to_WB,
    output logic [INSTR_W-1:0] InstrType_Mem_to_WB,
    output logic [2:0]         Tnew_WAddr_Mem_to_WB,
    output logic [4:0]         RAddr0_Mem,
    output logic [4:0]         RAddr1_Mem,
    output logic [4:0]         RegWriteAddr_Mem,
    output logic [2:0]         Tuse_RAddr0_Mem,
    output logic [2:0]         Tuse_RAddr1_Mem,
    output logic [2:0]         Tnew_WAddr_Mem,
    output logic [31:0]        bypass_Mem
);

    localparam int unsigned AW = $clog2(DM_WORDS);

    logic [AW-1:0]      w_word_idx;
    logic [31:0]        w_st_src;
    logic [31:0]        w_dm_wdata;
    logic [31:0]        w_dm_rdata;
    logic [31:0]        w_ld_data;
    logic [3:0]         w_dm_be;
    logic               w_is_load;
    logic [2:0]         w_tnew_dec;

    logic [31:0]        r_pc;
    logic [31:0]        r_alu;
    logic [31:0]        r_dm_rd;
    logic [4:0]         r_waddr;
    logic [INSTR_W-1:0] r_instr;
    logic [2:0]         r_tnew;

    assign w_word_idx = ALUOut_EX_to_Mem[AW+1:2];
    assign w_tnew_dec = sat_dec3(Tnew_WAddr_EX_to_Mem);

    assign RAddr0_Mem       = RAddr0_EX_to_Mem;
    assign RAddr1_Mem       = RAddr1_EX_to_Mem;
    assign RegWriteAddr_Mem = RegWriteAddr_EX_to_Mem;
    assign Tuse_RAddr0_Mem  = sat_dec3(Tuse_RAddr0_EX_to_Mem);
    assign Tuse_RAddr1_Mem  = sat_dec3(Tuse_RAddr1_EX_to_Mem);
    assign Tnew_WAddr_Mem   = w_tnew_dec;
    assign bypass_Mem       = ALUOut_EX_to_Mem;

`ifdef DM_SUBWORD_EN
    logic [31:0] w_byte_lane;
    logic [31:0] w_half_lane;
    assign w_byte_lane = w_dm_rdata >> {ALUOut_EX_to_Mem[1:0], 3'b000};
    assign w_half_lane = w_dm_rdata >> {ALUOut_EX_to_Mem[1], 4'b0000};
`endif

    always_comb begin
        w_st_src   = (dmwd_sel_e'(DMWriteDataBypassCtrl_Mem) == DMWD_SEL_WB) ?
                     bypass_WB : DMWriteData_EX_to_Mem;
        w_dm_wdata = w_st_src;
        w_dm_be    = '0;
        w_is_load  = InstrType_EX_to_Mem[I_LW];
        w_ld_data  = w_dm_rdata;
`ifdef DM_SUBWORD_EN
        // Subword stores replicate the lane so the byte enables alone pick the target bytes.
        if (InstrType_EX_to_Mem[I_SW]) begin
            w_dm_be = '1;
        end else if (InstrType_EX_to_Mem[I_SH]) begin
            w_dm_be    = ALUOut_EX_to_Mem[1] ? 4'b1100 : 4'b0011;
            w_dm_wdata = {2{w_st_src[15:0]}};
        end else if (InstrType_EX_to_Mem[I_SB]) begin
            w_dm_be    = 4'b0001 << ALUOut_EX_to_Mem[1:0];
            w_dm_wdata = {4{w_st_src[7:0]}};
        end
        w_is_load = InstrType_EX_to_Mem[I_LW]  | InstrType_EX_to_Mem[I_LB] |
                    InstrType_EX_to_Mem[I_LBU] | InstrType_EX_to_Mem[I_LH] |
                    InstrType_EX_to_Mem[I_LHU];
        if (InstrType_EX_to_Mem[I_LB]) begin
            w_ld_data = {{24{w_byte_lane[7]}}, w_byte_lane[7:0]};
        end else if (InstrType_EX_to_Mem[I_LBU]) begin
            w_ld_data = {24'd0, w_byte_lane[7:0]};
        end else if (InstrType_EX_to_Mem[I_LH]) begin
            w_ld_data = {{16{w_half_lane[15]}}, w_half_lane[15:0]};
        end else if (InstrType_EX_to_Mem[I_LHU]) begin
            w_ld_data = {16'd0, w_half_lane[15:0]};
        end
`else
        if (InstrType_EX_to_Mem[I_SW]) begin
            w_dm_be = '1;
        end
`endif
    end

    dm_ram #(
        .DM_WORDS(DM_WORDS)
    ) u_dm_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_be    (w_dm_be),
        .i_addr  (w_word_idx),
        .i_wdata (w_dm_wdata),
        .o_rdata (w_dm_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_alu   <= '0;
            r_dm_rd <= '0;
            r_waddr <= '0;
            r_instr <= INSTR_SLL;
            r_tnew  <= '0;
        end else begin
            r_pc    <= PC_EX_to_Mem;
            r_alu   <= ALUOut_EX_to_Mem;
            r_dm_rd <= w_is_load ? w_ld_data : '0;
            r_waddr <= RegWriteAddr_EX_to_Mem;
            r_instr <= InstrType_EX_to_Mem;
            r_tnew  <= w_tnew_dec;
        end
    end

    assign PC_Mem_to_WB           = r_pc;
    assign ALUOut_Mem_to_WB       = r_alu;
    assign DMReadData_Mem_to_WB   = r_dm_rd;
    assign RegWriteAddr_Mem_to_WB = r_waddr;
    assign InstrType_Mem_to_WB    = r_instr;
    assign Tnew_WAddr_Mem_to_WB   = r_tnew;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; the subword section is built only with DM_SUBWORD_EN.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        PC_EX_to_Mem, ALUOut_EX_to_Mem, DMWriteData_EX_to_Mem, bypass_WB;
    logic [4:0]         RAddr0_EX_to_Mem, RAddr1_EX_to_Mem, RegWriteAddr_EX_to_Mem;
    logic [INSTR_W-1:0] InstrType_EX_to_Mem;
    logic [2:0]         Tuse_RAddr0_EX_to_Mem, Tuse_RAddr1_EX_to_Mem, Tnew_WAddr_EX_to_Mem;
    logic               DMWriteDataBypassCtrl_Mem;
    logic [31:0]        PC_Mem_to_WB, ALUOut_Mem_to_WB, DMReadData_Mem_to_WB, bypass_Mem;
    logic [4:0]         RegWriteAddr_Mem_to_WB, RAddr0_Mem, RAddr1_Mem, RegWriteAddr_Mem;
    logic [INSTR_W-1:0] InstrType_Mem_to_WB;
    logic [2:0]         Tnew_WAddr_Mem_to_WB, Tuse_RAddr0_Mem, Tuse_RAddr1_Mem, Tnew_WAddr_Mem;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mem_stage #(
        .DM_WORDS (4096),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .PC_EX_to_Mem              (PC_EX_to_Mem),
        .ALUOut_EX_to_Mem          (ALUOut_EX_to_Mem),
        .DMWriteData_EX_to_Mem     (DMWriteData_EX_to_Mem),
        .RAddr0_EX_to_Mem          (RAddr0_EX_to_Mem),
        .RAddr1_EX_to_Mem          (RAddr1_EX_to_Mem),
        .RegWriteAddr_EX_to_Mem    (RegWriteAddr_EX_to_Mem),
        .InstrType_EX_to_Mem       (InstrType_EX_to_Mem),
        .Tuse_RAddr0_EX_to_Mem     (Tuse_RAddr0_EX_to_Mem),
        .Tuse_RAddr1_EX_to_Mem     (Tuse_RAddr1_EX_to_Mem),
        .Tnew_WAddr_EX_to_Mem      (Tnew_WAddr_EX_to_Mem),
        .bypass_WB                 (bypass_WB),
        .DMWriteDataBypassCtrl_Mem (DMWriteDataBypassCtrl_Mem),
        .PC_Mem_to_WB              (PC_Mem_to_WB),
        .ALUOut_Mem_to_WB          (ALUOut_Mem_to_WB),
        .DMReadData_Mem_to_WB      (DMReadData_Mem_to_WB),
        .RegWriteAddr_Mem_to_WB    (RegWriteAddr_Mem_to_WB),
        .InstrType_Mem_to_WB       (InstrType_Mem_to_WB),
        .Tnew_WAddr_Mem_to_WB      (Tnew_WAddr_Mem_to_WB),
        .RAddr0_Mem                (RAddr0_Mem),
        .RAddr1_Mem                (RAddr1_Mem),
        .RegWriteAddr_Mem          (RegWriteAddr_Mem),
        .Tuse_RAddr0_Mem           (Tuse_RAddr0_Mem),
        .Tuse_RAddr1_Mem           (Tuse_RAddr1_Mem),
        .Tnew_WAddr_Mem            (Tnew_WAddr_Mem),
        .bypass_Mem                (bypass_Mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned idx, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] wdata);
        InstrType_EX_to_Mem      = '0;
        InstrType_EX_to_Mem[idx] = 1'b1;
        PC_EX_to_Mem             = pc;
        ALUOut_EX_to_Mem         = alu;
        DMWriteData_EX_to_Mem    = wdata;
    endtask

    initial begin
        reset                     = 1'b0;
        RAddr0_EX_to_Mem          = 5'd3;
        RAddr1_EX_to_Mem          = 5'd4;
        RegWriteAddr_EX_to_Mem    = 5'd9;
        Tuse_RAddr0_EX_to_Mem     = 3'd0;
        Tuse_RAddr1_EX_to_Mem     = 3'd0;
        Tnew_WAddr_EX_to_Mem      = 3'd3;
        bypass_WB                 = 32'h0;
        DMWriteDataBypassCtrl_Mem = 1'b0;
        drive(I_LW, 32'h0000_0100, 32'h0000_0010, 32'h0);

        step();
        step();
        chk("rst_pc",    64'(PC_Mem_to_WB),           64'h3000);
        chk("rst_instr", 64'(InstrType_Mem_to_WB),    64'h1);
        chk("rst_tnew",  64'(Tnew_WAddr_Mem_to_WB),   64'h0);
        chk("rst_alu",   64'(ALUOut_Mem_to_WB),       64'h0);
        chk("rst_waddr", 64'(RegWriteAddr_Mem_to_WB), 64'h0);
        chk("rst_dmrd",  64'(DMReadData_Mem_to_WB),   64'h0);

        // sw 0x10 <- DEADBEEF, then lw 0x10 next cycle
        reset = 1'b1;
        drive(I_SW, 32'h0000_3000, 32'h0000_0010, 32'hDEAD_BEEF);
        #1;
        chk("bypass_mem", 64'(bypass_Mem), 64'h10);
        chk("raddr0_mem", 64'(RAddr0_Mem), 64'h3);
        step();
        chk("sw_dmrd_zero", 64'(DMReadData_Mem_to_WB), 64'h0);
        chk("sw_pc",        64'(PC_Mem_to_WB),         64'h3000);
        chk("sw_tnew",      64'(Tnew_WAddr_Mem_to_WB), 64'h2);
        drive(I_LW, 32'h0000_3004, 32'h0000_0010, 32'h0);
        step();
        chk("lw_deadbeef", 64'(DMReadData_Mem_to_WB),   64'hDEAD_BEEF);
        chk("lw_pc",       64'(PC_Mem_to_WB),           64'h3004);
        chk("lw_waddr",    64'(RegWriteAddr_Mem_to_WB), 64'h9);

        // store data taken from WB bypass
        DMWriteDataBypassCtrl_Mem = 1'b1;
        bypass_WB                 = 32'h1234_5678;
        drive(I_SW, 32'h0000_3008, 32'h0000_0020, 32'hAAAA_AAAA);
        step();
        DMWriteDataBypassCtrl_Mem = 1'b0;
        drive(I_LW, 32'h0000_300C, 32'h0000_0020, 32'h0);
        step();
        chk("lw_bypass", 64'(DMReadData_Mem_to_WB), 64'h1234_5678);

        // saturating decrement of hazard timing
        Tnew_WAddr_EX_to_Mem  = 3'd2;
        Tuse_RAddr0_EX_to_Mem = 3'd7;
        Tuse_RAddr1_EX_to_Mem = 3'd0;
        drive(I_ADDU, 32'h0000_3010, 32'h0000_0010, 32'h0);
        #1;
        chk("tnew_2",  64'(Tnew_WAddr_Mem),  64'h1);
        chk("tuse0_7", 64'(Tuse_RAddr0_Mem), 64'h6);
        chk("tuse1_0", 64'(Tuse_RAddr1_Mem), 64'h0);
        step();
        chk("tnew_wb",     64'(Tnew_WAddr_Mem_to_WB), 64'h1);
        chk("nonload_dm",  64'(DMReadData_Mem_to_WB), 64'h0);
        chk("nonload_ins", 64'(InstrType_Mem_to_WB),  64'h2);
        Tnew_WAddr_EX_to_Mem = 3'd0;
        #1;
        chk("tnew_0", 64'(Tnew_WAddr_Mem), 64'h0);

        // address wrap: 0x4010 aliases 0x0010
        drive(I_SW, 32'h0000_3014, 32'h0000_4010, 32'hCAFE_F00D);
        step();
        drive(I_LW, 32'h0000_3018, 32'h0000_0010, 32'h0);
        step();
        chk("wrap_lw", 64'(DMReadData_Mem_to_WB), 64'hCAFE_F00D);

        // one-cycle reset with a sw presented
        reset = 1'b0;
        drive(I_SW, 32'h0000_301C, 32'h0000_0030, 32'h0000_0055);
        step();
        chk("rst2_pc",   64'(PC_Mem_to_WB),         64'h3000);
        chk("rst2_dmrd", 64'(DMReadData_Mem_to_WB), 64'h0);
        reset = 1'b1;
        drive(I_LW, 32'h0000_3020, 32'h0000_0030, 32'h0);
        step();
        chk("rst2_lw30", 64'(DMReadData_Mem_to_WB), 64'h0);
        drive(I_LW, 32'h0000_3024, 32'h0000_0010, 32'h0);
        step();
        chk("rst2_lw10", 64'(DMReadData_Mem_to_WB), 64'h0);

        drive(I_SB, 32'h0000_3028, 32'h0000_0021, 32'h0000_0080);
        step();
`ifdef DM_SUBWORD_EN
        drive(I_LB, 32'h0000_302C, 32'h0000_0021, 32'h0);
        step();
        chk("lb",  64'(DMReadData_Mem_to_WB), 64'hFFFF_FF80);
        drive(I_LBU, 32'h0000_3030, 32'h0000_0021, 32'h0);
        step();
        chk("lbu", 64'(DMReadData_Mem_to_WB), 64'h0000_0080);
        drive(I_LW, 32'h0000_3034, 32'h0000_0020, 32'h0);
        step();
        chk("sb_lw", 64'(DMReadData_Mem_to_WB), 64'h0000_8000);
        drive(I_LH, 32'h0000_3038, 32'h0000_0020, 32'h0);
        step();
        chk("lh",  64'(DMReadData_Mem_to_WB), 64'hFFFF_8000);
        drive(I_LHU, 32'h0000_303C, 32'h0000_0020, 32'h0);
        step();
        chk("lhu", 64'(DMReadData_Mem_to_WB), 64'h0000_8000);
`else
        drive(I_LW, 32'h0000_302C, 32'h0000_0020, 32'h0);
        step();
        chk("sb_ignored", 64'(DMReadData_Mem_to_WB), 64'h0);
        drive(I_SW, 32'h0000_3030, 32'h0000_0020, 32'h0000_8000);
        step();
        drive(I_LB, 32'h0000_3034, 32'h0000_0021, 32'h0);
        step();
        chk("lb_nonmem", 64'(DMReadData_Mem_to_WB), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
